// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle EX-stage execute unit driven by the 4-bit ALUCtrl code.
// Logic, add/sub, compare and lui finish in one cycle. Arithmetic right shifts
// iterate one bit per cycle. Handshake: start_i/ready_o in, done_o pulse out.
module alu_seq_exec #(
  parameter int DW  = 32,
  parameter int SHW = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [3:0]     ALUCtrl_i,
  input  logic [DW-1:0]  src1_i,
  input  logic [DW-1:0]  src2_i,
  input  logic [SHW-1:0] shamt_i,
  input  logic           cmp_unsigned_i,
  output logic           ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [DW-1:0]  result_o,
  output logic           zero_o,
  output logic           overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [SHW-1:0] r_cnt;
  logic [DW-1:0]  r_shreg;
  logic [DW-1:0]  r_result;
  logic           r_zero;
  logic           r_ovf;

  logic           w_accept;
  logic           w_is_shift;
  logic           w_last_shift;
  logic [DW-1:0]  w_sum;
  logic [DW-1:0]  w_diff;
  logic           w_lt;
  logic [DW-1:0]  w_op_result;
  logic           w_op_ovf;
  logic [DW-1:0]  w_shr;

  // A request is taken in any state that advertises ready (IDLE or DONE).
  assign w_accept     = start_i && (r_state != S_SHIFT);
  // A zero shift amount needs no iteration, so it completes like a one-cycle op.
  assign w_is_shift   = (ALUCtrl_i == 4'b1000) && (shamt_i != '0);
  assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == SHW'(1));
  assign w_shr        = {r_shreg[DW-1], r_shreg[DW-1:1]};

  // Single-cycle operation results, evaluated directly on the input operands.
  always_comb begin
    w_sum       = src1_i + src2_i;
    w_diff      = src1_i - src2_i;
    w_lt        = cmp_unsigned_i ? (src1_i < src2_i)
                                 : ($signed(src1_i) < $signed(src2_i));
    w_op_result = '0;
    w_op_ovf    = 1'b0;
    case (ALUCtrl_i)
      4'b0000: w_op_result = src1_i & src2_i;
      4'b0001: w_op_result = src1_i | src2_i;
      4'b0010: begin
        w_op_result = w_sum;
        w_op_ovf    = (src1_i[DW-1] == src2_i[DW-1]) && (w_sum[DW-1] != src1_i[DW-1]);
      end
      4'b0110: begin
        w_op_result = w_diff;
        w_op_ovf    = (src1_i[DW-1] != src2_i[DW-1]) && (w_diff[DW-1] != src1_i[DW-1]);
      end
      4'b0111: w_op_result = {{(DW-1){1'b0}}, w_lt};
      4'b1000: w_op_result = src2_i;
      4'b1001: w_op_result = {src2_i[15:0], {(DW-16){1'b0}}};
      4'b1010: w_op_result = w_diff;
      default: w_op_result = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_state_next = r_state;
    ready_o      = (r_state != S_SHIFT);
    busy_o       = (r_state != S_IDLE);
    done_o       = (r_state == S_DONE);
    if (w_accept) begin
      w_state_next = w_is_shift ? S_SHIFT : S_DONE;
    end else if (w_last_shift) begin
      w_state_next = S_DONE;
    end else if (r_state == S_DONE) begin
      w_state_next = S_IDLE;
    end
  end

  // Datapath: load shifter or results at accept, iterate the shifter in SHIFT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      if (w_is_shift) begin
        r_shreg <= src2_i;
        r_cnt   <= shamt_i;
      end else begin
        r_result <= w_op_result;
        r_zero   <= (w_op_result == '0);
        r_ovf    <= w_op_ovf;
      end
    end else if (r_state == S_SHIFT) begin
      r_cnt <= r_cnt - SHW'(1);
      if (w_last_shift) begin
        r_result <= w_shr;
        r_zero   <= (w_shr == '0);
        r_ovf    <= 1'b0;
      end else begin
        r_shreg <= w_shr;
      end
    end
  end

  assign result_o   = r_result;
  assign zero_o     = r_zero;
  assign overflow_o = r_ovf;

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Multi-cycle execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder and carries out the operation; it is the receiving end of the ALUCtrl encoding.
- Logic, add/sub, compare and lui complete in one cycle. sra/srav run as an iterative 1-bit-per-cycle shifter.
- Sits in the EX stage of the multi-cycle CPU, between the register-file/immediate muxes and the writeback/branch logic, with a start/ready/done handshake.

Parameters:
- DW, 32, datapath width.
- SHW, 5, shift-amount width (log2 DW).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; accepted only when ready_o=1.
- ALUCtrl_i  in  4  operation code, sampled at accept.
- src1_i  in  DW  operand A, sampled at accept.
- src2_i  in  DW  operand B / shift source, sampled at accept.
- shamt_i  in  SHW  shift amount, sampled at accept. The datapath muxes in either the instruction shamt or src1[4:0].
- cmp_unsigned_i  in  1  1 = unsigned compare for 0111 (sltiu); sampled at accept.
- ready_o  out  1  1 when not in SHIFT.
- busy_o  out  1  1 in SHIFT or DONE.
- done_o  out  1  one-cycle pulse; result valid.
- result_o  out  DW  registered result; held until next done.
- zero_o  out  1  result_o==0; registered with result_o.
- overflow_o  out  1  signed overflow for 0010/0110, else 0.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, result_o=0, zero_o=1, overflow_o=0, done_o=0, busy_o=0, ready_o=1, shift counter=0. Reset has priority over everything, including mid-shift; any in-flight operation is discarded and done_o is not raised.
- States and outputs:
  - IDLE: ready_o=1, busy_o=0.
  - SHIFT: ready_o=0, busy_o=1.
  - DONE: ready_o=1, busy_o=1, done_o=1.
- Accept: start_i&ready_o at edge T latches ALUCtrl_i, src1_i, src2_i, shamt_i and cmp_unsigned_i. start_i while ready_o=0 is ignored and not queued.
- Opcodes (A=src1, B=src2):
  - 0000: A&B.
  - 0001: A|B.
  - 0010: A+B, mod 2^DW.
  - 0110: A-B, mod 2^DW.
  - 0111: {0,lt}. lt is a signed compare, or unsigned if cmp_unsigned=1.
  - 1000: B>>>shamt, arithmetic, sign-filled.
  - 1001: {B[15:0],16'b0}.
  - 1010: A-B (bne compare; the branch unit uses !zero_o).
  - Any other code: result 0, completes in 1 cycle, overflow 0.
- Overflow: add sets it when A and B have the same sign and the sum sign differs. Sub sets it when A and B signs differ and the result sign differs from A.
- Single-cycle ops: accept at T -> DONE during cycle T+1. result_o, zero_o and overflow_o update at edge T.
- sra with shamt=0: behaves as single-cycle, result=B.
- sra with shamt=N>0: enter SHIFT at T, counter=N, internal reg=B. Each SHIFT cycle does reg=reg>>>1 and counter-1. When the counter reaches 0, load result_o and go to DONE, so done_o is asserted in cycle T+N+1.
- During SHIFT, result_o keeps its previous value.
- DONE lasts exactly one cycle. In DONE:
  - With a new start_i: accept it (back-to-back issue), go to DONE or SHIFT per the new opcode.
  - Without start_i: go to IDLE.
- result_o, zero_o and overflow_o are stable from done until the next done or reset.

Test Plan:
- Reset: assert rst_i 2 cycles mid-operation -> next cycle ready_o=1, busy_o=0, done_o=0, result_o=0, zero_o=1.
- Add overflow: ALUCtrl=0010, A=0x7FFFFFFF, B=1 -> one cycle later done_o=1, result_o=0x80000000, overflow_o=1, zero_o=0.
- Sub and bne: 0110 with A=5, B=5 -> result 0, zero_o=1. Then 1010 with A=5, B=3 -> result 2, zero_o=0.
- Compare: 0111, A=0xFFFFFFFF, B=1, cmp_unsigned=0 -> result 1. Same operands with cmp_unsigned=1 -> result 0.
- Iterative shift: 1000, B=0x80000000, shamt=4, start at T -> ready_o=0 for cycles T+1..T+4, done_o only in T+5, result 0xF8000000. shamt=0 -> done at T+1, result 0x80000000.
- Handshake edges:
  - start_i held high during SHIFT is ignored.
  - Back-to-back: start in the DONE cycle with lui B=0x1234 -> next cycle done_o=1, result 0x12340000.
  - rst_i mid-shift -> no done pulse.
